mem_port_arbiter: RTL and testbench

Shares one memory request/response port between the core's instruction fetch port and its load/store data port, enabling a single-port memory system. Placed between the core top-level and the memory/bus fabric. Grants requests with data-port priority plus an instruction anti-starvation counter. Tracks outstanding transactions in an in-order owner-tag FIFO so that each response is routed back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory request/response port between instruction fetch
//            and load/store; in-order responses are routed by an owner-tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned C_OUTST_X      = 2,
    parameter int unsigned C_STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,

    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,

    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,

    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqdvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,

    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,

    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqsize_o,
    output logic        mreqdvalid_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,

    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    localparam int unsigned        C_DEPTH    = 1 << C_OUTST_X;
    localparam int unsigned        C_SW       = $clog2(C_STARVE_LIMIT + 1);
    localparam logic [C_SW-1:0]    C_LIMIT    = C_STARVE_LIMIT[C_SW-1:0];
    localparam logic               C_OWN_INSTR = 1'b0;
    localparam logic               C_OWN_DATA  = 1'b1;
    localparam logic [1:0]         C_WORD_SIZE = 2'b10;

    logic                  r_lock;
    logic                  r_owner;
    logic [C_SW-1:0]       r_starve_cnt;
    logic [C_OUTST_X-1:0]  r_wr_ptr;
    logic [C_OUTST_X-1:0]  r_rd_ptr;
    logic [C_OUTST_X:0]    r_count;
    logic                  r_tag_mem [0:C_DEPTH-1];

    logic w_run;
    logic w_owner;
    logic w_owner_valid;
    logic w_full;
    logic w_empty;
    logic w_mreq_valid;
    logic w_owner_ready;
    logic w_mreq_fire;
    logic w_ifire;
    logic w_dfire;
    logic w_head;
    logic w_rsp_ready;
    logic w_rsp_fire;

    // Nothing handshakes while held in reset or with the clock enable low.
    assign w_run = clk_en_i & resetb_i;

    // A stalled request keeps its owner so the memory side sees a stable request.
    always_comb begin
        w_owner = r_owner;
        if (!r_lock) begin
            if (dreqvalid_i && ireqvalid_i) begin
                w_owner = (r_starve_cnt == C_LIMIT) ? C_OWN_INSTR : C_OWN_DATA;
            end else if (dreqvalid_i) begin
                w_owner = C_OWN_DATA;
            end else begin
                w_owner = C_OWN_INSTR;
            end
        end
    end

    assign w_full        = r_count[C_OUTST_X];
    assign w_empty       = (r_count == '0);
    assign w_owner_valid = (w_owner == C_OWN_DATA) ? dreqvalid_i : ireqvalid_i;
    assign w_mreq_valid  = w_run & w_owner_valid & ~w_full;
    assign w_owner_ready = w_run & mreqready_i & ~w_full;
    assign w_mreq_fire   = w_mreq_valid & mreqready_i;
    assign w_ifire       = w_mreq_fire & (w_owner == C_OWN_INSTR);
    assign w_dfire       = w_mreq_fire & (w_owner == C_OWN_DATA);

    assign w_head        = r_tag_mem[r_rd_ptr];
    assign w_rsp_ready   = w_run & ~w_empty & (w_head ? drspready_i : irspready_i);
    assign w_rsp_fire    = w_rsp_ready & mrspvalid_i;

    assign ireqready_o   = w_owner_ready & (w_owner == C_OWN_INSTR);
    assign dreqready_o   = w_owner_ready & (w_owner == C_OWN_DATA);
    assign mreqvalid_o   = w_mreq_valid;

    always_comb begin
        mreqsize_o   = 2'b00;
        mreqdvalid_o = 1'b0;
        mreqhpl_o    = 2'b00;
        mreqaddr_o   = 32'h0;
        mreqdata_o   = 32'h0;
        if (resetb_i) begin
            if (w_owner == C_OWN_DATA) begin
                mreqsize_o   = dreqsize_i;
                mreqdvalid_o = dreqdvalid_i;
                mreqhpl_o    = dreqhpl_i;
                mreqaddr_o   = dreqaddr_i;
                mreqdata_o   = dreqdata_i;
            end else begin
                mreqsize_o   = C_WORD_SIZE;
                mreqhpl_o    = ireqhpl_i;
                mreqaddr_o   = ireqaddr_i;
            end
        end
    end

    assign mrspready_o = w_rsp_ready;
    assign irspvalid_o = w_run & mrspvalid_i & ~w_empty & ~w_head;
    assign drspvalid_o = w_run & mrspvalid_i & ~w_empty & w_head;
    assign irsprerr_o  = resetb_i & mrsprerr_i;
    assign drsprerr_o  = resetb_i & mrsprerr_i;
    assign drspwerr_o  = resetb_i & mrspwerr_i;
    assign irspdata_o  = resetb_i ? mrspdata_i : 32'h0;
    assign drspdata_o  = resetb_i ? mrspdata_i : 32'h0;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_lock  <= 1'b0;
            r_owner <= C_OWN_INSTR;
        end else if (clk_en_i) begin
            r_lock  <= w_mreq_valid & ~mreqready_i;
            r_owner <= w_owner;
        end
    end

    // Counts data grants taken while an instruction fetch is left waiting.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_starve_cnt <= '0;
        end else if (clk_en_i) begin
            if (!ireqvalid_i || w_ifire) begin
                r_starve_cnt <= '0;
            end else if (w_dfire && (r_starve_cnt != C_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_mreq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rsp_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_mreq_fire && !w_rsp_fire) begin
                r_count <= r_count + 1'b1;
            end else if (w_rsp_fire && !w_mreq_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk_i) begin
        if (w_mreq_fire) begin
            r_tag_mem[r_wr_ptr] <= w_owner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int unsigned C_OUTST_X      = 2;
    localparam int unsigned C_STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        resetb_i, clk_en_i;
    logic        ireqready_o, ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i, irspvalid_o, irsprerr_o;
    logic [31:0] irspdata_o;
    logic        dreqready_o, dreqvalid_i, dreqdvalid_i;
    logic [1:0]  dreqsize_i, dreqhpl_i;
    logic [31:0] dreqaddr_i, dreqdata_i;
    logic        drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
    logic [31:0] drspdata_o;
    logic        mreqready_i, mreqvalid_o, mreqdvalid_o;
    logic [1:0]  mreqsize_o, mreqhpl_o;
    logic [31:0] mreqaddr_o, mreqdata_o;
    logic        mrspready_o, mrspvalid_i, mrsprerr_i, mrspwerr_i;
    logic [31:0] mrspdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .C_OUTST_X      (C_OUTST_X),
        .C_STARVE_LIMIT (C_STARVE_LIMIT)
    ) dut (
        .clk_i        (clk),
        .resetb_i     (resetb_i),
        .clk_en_i     (clk_en_i),
        .ireqready_o  (ireqready_o),
        .ireqvalid_i  (ireqvalid_i),
        .ireqhpl_i    (ireqhpl_i),
        .ireqaddr_i   (ireqaddr_i),
        .irspready_i  (irspready_i),
        .irspvalid_o  (irspvalid_o),
        .irsprerr_o   (irsprerr_o),
        .irspdata_o   (irspdata_o),
        .dreqready_o  (dreqready_o),
        .dreqvalid_i  (dreqvalid_i),
        .dreqsize_i   (dreqsize_i),
        .dreqdvalid_i (dreqdvalid_i),
        .dreqhpl_i    (dreqhpl_i),
        .dreqaddr_i   (dreqaddr_i),
        .dreqdata_i   (dreqdata_i),
        .drspready_i  (drspready_i),
        .drspvalid_o  (drspvalid_o),
        .drsprerr_o   (drsprerr_o),
        .drspwerr_o   (drspwerr_o),
        .drspdata_o   (drspdata_o),
        .mreqready_i  (mreqready_i),
        .mreqvalid_o  (mreqvalid_o),
        .mreqsize_o   (mreqsize_o),
        .mreqdvalid_o (mreqdvalid_o),
        .mreqhpl_o    (mreqhpl_o),
        .mreqaddr_o   (mreqaddr_o),
        .mreqdata_o   (mreqdata_o),
        .mrspready_o  (mrspready_o),
        .mrspvalid_i  (mrspvalid_i),
        .mrsprerr_i   (mrsprerr_i),
        .mrspwerr_i   (mrspwerr_i),
        .mrspdata_i   (mrspdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return 32'hDEADBEEF ^ (a - 32'h100);
    endfunction

    // Vector table for single-cycle request-side behaviour from a clean state.
    typedef struct packed {
        logic       iv, dv, mrdy, en;
        logic [1:0] dsize;
        logic       ddv;
        logic       e_mv, e_ir, e_dr;
        logic [1:0] e_size;
        logic       e_dv;
        logic       e_sel_d;
    } vec_t;

    typedef struct packed { logic [31:0] addr; logic wr; } mreq_t;
    typedef struct packed { logic port; logic [31:0] data; logic rerr; logic werr; } exp_t;

    mreq_t mem_q[$];
    exp_t  sb_q[$];
    logic  gnt_log[$];

    int   i_left, d_left;
    logic d_wr, mem_rsp_en, werr_mode, spurious;

    task automatic drive_core();
        ireqvalid_i  = (i_left > 0);
        dreqvalid_i  = (d_left > 0);
        dreqdvalid_i = d_wr;
        dreqsize_i   = 2'b10;
        dreqdata_i   = dreqaddr_i ^ 32'h5555_0000;
    endtask

    task automatic mem_drive();
        mrspvalid_i = spurious | (mem_rsp_en & (mem_q.size() > 0));
        if (mem_q.size() > 0) begin
            mrspdata_i = rsp_of(mem_q[0].addr);
            mrsprerr_i = mem_q[0].addr[3];
            mrspwerr_i = mem_q[0].wr & werr_mode;
        end else begin
            mrspdata_i = 32'h0BAD_0000;
            mrsprerr_i = 1'b0;
            mrspwerr_i = werr_mode;
        end
    endtask

    // One clock: sample handshakes at the falling edge, then update stimulus after the rising edge.
    task automatic step();
        logic ifire, dfire, mfire, irf, drf, mrf;
        logic [31:0] caddr;
        exp_t  e;
        mreq_t m;
        @(negedge clk);
        ifire = ireqvalid_i & ireqready_o;
        dfire = dreqvalid_i & dreqready_o;
        mfire = mreqvalid_o & mreqready_i;
        irf   = irspvalid_o & irspready_i;
        drf   = drspvalid_o & drspready_i;
        mrf   = mrspvalid_i & mrspready_o;
        if (mfire) begin
            caddr = dfire ? dreqaddr_i : ireqaddr_i;
            check("req_single_grant", 32'(ifire ^ dfire), 32'd1);
            check("req_addr", mreqaddr_o, caddr);
            mem_q.push_back('{addr: mreqaddr_o, wr: mreqdvalid_o});
            e.port = dfire;
            e.data = rsp_of(caddr);
            e.rerr = caddr[3];
            e.werr = dfire & dreqdvalid_i & werr_mode;
            sb_q.push_back(e);
            gnt_log.push_back(dfire);
        end else begin
            check("core_accept_without_mem", 32'({ifire, dfire}), 32'd0);
        end
        check("rsp_ack_vs_forward", 32'(mrf), 32'(irf | drf));
        if (irf | drf) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got response with empty scoreboard, expected none");
            end else begin
                e = sb_q.pop_front();
                check("rsp_port", 32'({irf, drf}), e.port ? 32'd1 : 32'd2);
                check("rsp_data", drf ? drspdata_o : irspdata_o, e.data);
                check("rsp_rerr", 32'(drf ? drsprerr_o : irsprerr_o), 32'(e.rerr));
                if (drf) check("rsp_werr", 32'(drspwerr_o), 32'(e.werr));
            end
        end
        if (mrf && mem_q.size() > 0) m = mem_q.pop_front();
        @(posedge clk);
        #1;
        if (ifire) begin i_left--; ireqaddr_i += 32'd4; end
        if (dfire) begin d_left--; dreqaddr_i += 32'd4; end
        drive_core();
        mem_drive();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((i_left > 0 || d_left > 0 || sb_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(i_left + d_left + sb_q.size()), 32'd0);
    endtask

    task automatic check_grants(input string name, input logic [15:0] exp, input int n);
        check({name, "_count"}, 32'(gnt_log.size() >= n), 32'd1);
        for (int k = 0; k < n && k < gnt_log.size(); k++)
            check(name, 32'(gnt_log[k]), 32'(exp[k]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [31:0] stall_addr;
        vecs[0] = '{iv:1, dv:0, mrdy:1, en:1, dsize:2'b01, ddv:1, e_mv:1, e_ir:1, e_dr:0, e_size:2'b10, e_dv:0, e_sel_d:0};
        vecs[1] = '{iv:0, dv:1, mrdy:1, en:1, dsize:2'b01, ddv:1, e_mv:1, e_ir:0, e_dr:1, e_size:2'b01, e_dv:1, e_sel_d:1};
        vecs[2] = '{iv:1, dv:1, mrdy:1, en:1, dsize:2'b00, ddv:0, e_mv:1, e_ir:0, e_dr:1, e_size:2'b00, e_dv:0, e_sel_d:1};
        vecs[3] = '{iv:1, dv:1, mrdy:0, en:1, dsize:2'b11, ddv:1, e_mv:1, e_ir:0, e_dr:0, e_size:2'b11, e_dv:1, e_sel_d:1};
        vecs[4] = '{iv:1, dv:0, mrdy:1, en:0, dsize:2'b01, ddv:1, e_mv:0, e_ir:0, e_dr:0, e_size:2'b10, e_dv:0, e_sel_d:0};
        vecs[5] = '{iv:0, dv:1, mrdy:0, en:1, dsize:2'b10, ddv:0, e_mv:1, e_ir:0, e_dr:0, e_size:2'b10, e_dv:0, e_sel_d:1};

        resetb_i = 1'b0; clk_en_i = 1'b1;
        i_left = 0; d_left = 0; d_wr = 1'b0;
        mem_rsp_en = 1'b1; werr_mode = 1'b0; spurious = 1'b0;
        ireqhpl_i = 2'b01; dreqhpl_i = 2'b10;
        ireqaddr_i = 32'h0000_1000; dreqaddr_i = 32'h0000_2004;
        dreqsize_i = 2'b10; dreqdvalid_i = 1'b0; dreqdata_i = 32'hCAFE_F00D;
        irspready_i = 1'b1; drspready_i = 1'b1; mreqready_i = 1'b1;
        ireqvalid_i = 1'b1; dreqvalid_i = 1'b1;
        mrspvalid_i = 1'b1; mrsprerr_i = 1'b1; mrspwerr_i = 1'b1; mrspdata_i = 32'h1234_5678;

        // Held in reset with every input active.
        repeat (2) @(negedge clk);
        check("rst_ireqready", 32'(ireqready_o), 0);
        check("rst_dreqready", 32'(dreqready_o), 0);
        check("rst_mreqvalid", 32'(mreqvalid_o), 0);
        check("rst_mrspready", 32'(mrspready_o), 0);
        check("rst_irspvalid", 32'(irspvalid_o), 0);
        check("rst_drspvalid", 32'(drspvalid_o), 0);
        check("rst_mreqaddr", mreqaddr_o, 0);
        check("rst_irspdata", irspdata_o, 0);

        // Table: each vector evaluated combinationally from a freshly reset state.
        mrspvalid_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            ireqvalid_i = vecs[v].iv; dreqvalid_i = vecs[v].dv;
            mreqready_i = vecs[v].mrdy; clk_en_i = vecs[v].en;
            dreqsize_i = vecs[v].dsize; dreqdvalid_i = vecs[v].ddv;
            resetb_i = 1'b1;
            #2;
            check("vec_mreqvalid", 32'(mreqvalid_o), 32'(vecs[v].e_mv));
            check("vec_ireqready", 32'(ireqready_o), 32'(vecs[v].e_ir));
            check("vec_dreqready", 32'(dreqready_o), 32'(vecs[v].e_dr));
            check("vec_mreqsize", 32'(mreqsize_o), 32'(vecs[v].e_size));
            check("vec_mreqdvalid", 32'(mreqdvalid_o), 32'(vecs[v].e_dv));
            check("vec_mreqaddr", mreqaddr_o, vecs[v].e_sel_d ? 32'h0000_2004 : 32'h0000_1000);
            check("vec_mreqdata", mreqdata_o, vecs[v].e_sel_d ? 32'hCAFE_F00D : 32'h0);
            check("vec_mreqhpl", 32'(mreqhpl_o), vecs[v].e_sel_d ? 32'd2 : 32'd1);
            check("vec_mrspready_empty", 32'(mrspready_o), 0);
            #1 resetb_i = 1'b0;
        end

        // Release with no requests pending.
        ireqvalid_i = 1'b0; dreqvalid_i = 1'b0; mreqready_i = 1'b1; clk_en_i = 1'b1;
        dreqdvalid_i = 1'b0; mrspvalid_i = 1'b1; mrsprerr_i = 1'b0; mrspwerr_i = 1'b0;
        @(negedge clk);
        resetb_i = 1'b1;
        @(posedge clk);
        #1;
        check("idle_mreqvalid", 32'(mreqvalid_o), 0);
        check("idle_mrspready", 32'(mrspready_o), 0);
        check("idle_rspvalid", 32'({irspvalid_o, drspvalid_o}), 0);
        mem_drive();

        // Single instruction fetch.
        ireqaddr_i = 32'h100; i_left = 1; drive_core();
        #1;
        check("fetch_mreqsize", 32'(mreqsize_o), 32'd2);
        check("fetch_mreqdvalid", 32'(mreqdvalid_o), 0);
        check("fetch_mreqaddr", mreqaddr_o, 32'h100);
        step();
        #1;
        check("fetch_irspvalid", 32'(irspvalid_o), 1);
        check("fetch_irspdata", irspdata_o, 32'hDEADBEEF);
        check("fetch_drspvalid", 32'(drspvalid_o), 0);
        drain("fetch_drain");

        // Starvation limit: continuous contention.
        gnt_log.delete();
        ireqaddr_i = 32'h1000; dreqaddr_i = 32'h8000;
        i_left = 2; d_left = 8; drive_core();
        drain("starve_drain");
        check_grants("starve_seq", 16'b0000_0000_0111_0111, 8);

        // Data owns a stalled request while the instruction port is close to starving.
        gnt_log.delete();
        i_left = 1; d_left = 4; drive_core();
        step(); step();
        mreqready_i = 1'b0;
        stall_addr = dreqaddr_i;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_d_addr", mreqaddr_o, stall_addr);
            check("stall_d_valid", 32'(mreqvalid_o), 1);
            check("stall_d_readies", 32'({ireqready_o, dreqready_o}), 0);
            step();
        end
        mreqready_i = 1'b1;
        drain("stall_d_drain");
        check_grants("stall_d_seq", 16'b0000_0000_0001_0111, 5);

        // Locked instruction owner is not pre-empted by a later data request.
        gnt_log.delete();
        i_left = 1; d_left = 0; mreqready_i = 1'b0; drive_core();
        stall_addr = ireqaddr_i;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin d_left = 1; drive_core(); end
            #1;
            check("lock_i_addr", mreqaddr_o, stall_addr);
            check("lock_i_size", 32'(mreqsize_o), 32'd2);
            check("lock_i_dready", 32'(dreqready_o), 0);
            step();
        end
        mreqready_i = 1'b1;
        drain("lock_i_drain");
        check_grants("lock_i_seq", 16'b0000_0000_0000_0010, 2);

        // FIFO fill to depth, blocked push during pop, then pointer wrap.
        gnt_log.delete();
        mem_rsp_en = 1'b0; i_left = 4; d_left = 4; drive_core(); mem_drive();
        repeat (4) step();
        #1;
        check("full_mreqvalid", 32'(mreqvalid_o), 0);
        check("full_readies", 32'({ireqready_o, dreqready_o}), 0);
        step(); step();
        mem_rsp_en = 1'b1; mem_drive();
        #1;
        check("full_pop_ready", 32'(mrspready_o), 1);
        check("full_push_blocked", 32'(mreqvalid_o), 0);
        step();
        #1;
        check("refill_after_pop", 32'(mreqvalid_o), 1);
        drain("wrap_drain");
        check_grants("wrap_seq", 16'b0000_0000_0001_0111, 8);

        // Store with write error, then a spurious response on an empty FIFO.
        werr_mode = 1'b1; d_wr = 1'b1; d_left = 1; drive_core();
        step();
        #1;
        check("store_drspvalid", 32'(drspvalid_o), 1);
        check("store_drspwerr", 32'(drspwerr_o), 1);
        check("store_irspvalid", 32'(irspvalid_o), 0);
        drain("store_drain");
        spurious = 1'b1; mem_drive();
        #1;
        check("spur_mrspready", 32'(mrspready_o), 0);
        check("spur_rspvalid", 32'({irspvalid_o, drspvalid_o}), 0);
        step(); step();
        spurious = 1'b0; werr_mode = 1'b0; d_wr = 1'b0; mem_drive();

        // Clock enable low blocks every handshake.
        clk_en_i = 1'b0; i_left = 1; drive_core();
        #1;
        check("clken_mreqvalid", 32'(mreqvalid_o), 0);
        check("clken_ireqready", 32'(ireqready_o), 0);
        step(); step();
        check("clken_no_grant", 32'(i_left), 1);
        clk_en_i = 1'b1;
        drain("clken_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
